fb_line_buffer: RTL and testbench

FB_LINE_BUFFER -- requirements
Module: fb_line_buffer

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/fb_line_buffer_if.sv | 16 +
 rtl/fb_line_ram.sv | 28 ++
 rtl/fb_line_buffer.sv | 127 ++++++++++++
 tb/tb_fb_line_buffer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: framebuffer geometry defaults, pixel/coordinate
// widths and the line-buffer fill-state encoding.
package gpu_pkg;

  localparam int X_WIDTH_DEF  = 640;  // pixels per row
  localparam int Y_WIDTH_DEF  = 480;  // rows per frame
  localparam int FB_DEPTH_DEF = 24;   // R,G,B 8 bits each

  // Wide enough to carry out-of-range columns so they can be detected.
  localparam int X_COORD_W = 10;
  localparam int Y_COORD_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_FULL
  } fill_state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fb_line_buffer_if.sv
// Framebuffer -> line buffer pixel interface.
//   vld, x_coord, val : pixel write from the framebuffer side
//   row_done          : one-cycle request for the next row
//   frame_done        : one-cycle marker after the last row of a frame
interface fb_if;
  import gpu_pkg::*;

  logic                    vld;
  logic [X_COORD_W-1:0]    x_coord;
  logic [FB_DEPTH_DEF-1:0] val;
  logic                    row_done;
  logic                    frame_done;

  modport master (output vld, x_coord, val, input row_done, frame_done);
  modport slave  (input vld, x_coord, val, output row_done, frame_done);
endinterface

// File: rtl/fb_line_ram.sv
// Simple dual-port line RAM holding two row banks of X_WIDTH pixels.
// Address MSB selects the bank, lower bits the column. One write port,
// one read port with a registered (1-cycle) read.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates only when re=1
module fb_line_ram #(
  parameter int X_WIDTH = 640,
  parameter int DW      = 24,
  parameter int AW      = $clog2(X_WIDTH) + 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2][X_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW-1]][waddr[AW-2:0]] <= wdata;
    if (re) rdata <= mem[raddr[AW-1]][raddr[AW-2:0]];
  end

endmodule

// File: rtl/fb_line_buffer.sv
// Double-banked scan-line buffer. One bank fills from the framebuffer
// while the other is scanned out; roles swap at line_start_i once the fill
// bank holds a complete row, otherwise the old row is rescanned (underrun).
// Optional macro FB_UNDERRUN_CNT_EN enables the underrun counter.
//   clk, rst (sync, active-low)
//   fb_i            : framebuffer pixel interface (slave end)
//   line_start_i    : start-of-line pulse from scan timing
//   pix_rd_i/pix_x_i: scan read strobe / column
//   pix_val_o       : registered scan pixel
//   err_o           : sticky dropped-pixel flag
//   underrun_cnt_o  : saturating underrun count
module fb_line_buffer
  import gpu_pkg::*;
#(
  parameter int X_WIDTH  = X_WIDTH_DEF,
  parameter int Y_WIDTH  = Y_WIDTH_DEF,
  parameter int FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  fb_if.slave                        fb_i,
  input  logic                       line_start_i,
  input  logic                       pix_rd_i,
  input  logic [$clog2(X_WIDTH)-1:0] pix_x_i,
  output logic [FB_DEPTH-1:0]        pix_val_o,
  output logic                       err_o,
  output logic [15:0]                underrun_cnt_o
);

  localparam int XW = $clog2(X_WIDTH);
  localparam int CW = $clog2(X_WIDTH + 1);
  localparam int YW = clog2_min1(Y_WIDTH);
  localparam logic [X_COORD_W:0] X_LIM = (X_COORD_W + 1)'(X_WIDTH);

  fill_state_t   state;
  logic [CW-1:0] fill_cnt;
  logic [YW-1:0] row_cnt;
  logic          bank_sel;   // fill bank; scan bank is its complement
  logic          scan_vld;
  logic          rd_vld_q;
  logic          err_q;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;
  logic [FB_DEPTH-1:0] ram_q;

  assign in_range = {1'b0, fb_i.x_coord} < X_LIM;
  assign wr_en    = fb_i.vld && in_range && (state == ST_FILL);
  assign rd_en    = pix_rd_i && scan_vld;

  fb_line_ram #(
    .X_WIDTH (X_WIDTH),
    .DW      (FB_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({bank_sel, fb_i.x_coord[XW-1:0]}),
    .wdata (fb_i.val),
    .re    (rd_en),
    .raddr ({~bank_sel, pix_x_i}),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      fill_cnt        <= '0;
      row_cnt         <= '0;
      bank_sel        <= 1'b0;
      scan_vld        <= 1'b0;
      rd_vld_q        <= 1'b0;
      err_q           <= 1'b0;
      fb_i.row_done   <= 1'b0;
      fb_i.frame_done <= 1'b0;
    end else begin
      fb_i.row_done   <= 1'b0;
      fb_i.frame_done <= 1'b0;
      if (fb_i.vld && !wr_en) err_q    <= 1'b1;
      if (rd_en)              rd_vld_q <= 1'b1;
      if (wr_en)              fill_cnt <= fill_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          state         <= ST_REQ;
          fb_i.row_done <= 1'b1;
        end
        ST_REQ:  state <= ST_FILL;
        ST_FILL: if (wr_en && fill_cnt == CW'(X_WIDTH - 1)) state <= ST_FULL;
        ST_FULL: begin
          if (line_start_i) begin
            bank_sel      <= ~bank_sel;
            fill_cnt      <= '0;
            scan_vld      <= 1'b1;
            state         <= ST_REQ;
            fb_i.row_done <= 1'b1;
            if (row_cnt == YW'(Y_WIDTH - 1)) begin
              row_cnt         <= '0;
              fb_i.frame_done <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The RAM output register is not reset; rd_vld_q masks it until the
  // first read of a valid scan bank, after which the RAM register holds.
  assign pix_val_o = rd_vld_q ? ram_q : '0;
  assign err_o     = err_q;

`ifdef FB_UNDERRUN_CNT_EN
  logic [15:0] und_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      und_q <= '0;
    end else if (line_start_i && state != ST_FULL && und_q != '1) begin
      und_q <= und_q + 1'b1;
    end
  end
  assign underrun_cnt_o = und_q;
`else
  assign underrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fb_line_buffer.sv
// Self-checking bench for fb_line_buffer (640 px rows, 4-row frames).
module tb_fb_line_buffer;
  import gpu_pkg::*;

  localparam int XT = 640;
  localparam int YT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic        pix_rd;
  logic [9:0]  pix_x;
  logic [23:0] pix_val;
  logic        err;
  logic [15:0] und;

  always #5 clk = ~clk;

  fb_if fb();

  fb_line_buffer #(.X_WIDTH(XT), .Y_WIDTH(YT), .FB_DEPTH(24)) dut (
    .clk            (clk),
    .rst            (rst),
    .fb_i           (fb),
    .line_start_i   (line_start),
    .pix_rd_i       (pix_rd),
    .pix_x_i        (pix_x),
    .pix_val_o      (pix_val),
    .err_o          (err),
    .underrun_cnt_o (und)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=after reset,1=requesting,2=accepting,3=row complete
  int          m_ph, m_cnt, m_row, m_und;
  bit          m_sv, m_err, m_rdone, m_fdone;
  logic [23:0] m_pix;
  logic [23:0] m_fill [XT];
  logic [23:0] m_scan [XT];
  int          rdone_seen, fdone_seen;

  task automatic tick();
    int ph0;
    bit ls, v, wr, rd;
    int xc, rx;
    logic [23:0] vv;
    ph0 = m_ph; ls = line_start; v = fb.vld; xc = int'(fb.x_coord);
    vv = fb.val; rd = pix_rd; rx = int'(pix_x);
    wr = v && (xc < XT) && (ph0 == 2);
    @(posedge clk);
    if (!rst) begin
      m_ph = 0; m_cnt = 0; m_row = 0; m_und = 0;
      m_sv = 0; m_err = 0; m_rdone = 0; m_fdone = 0; m_pix = '0;
    end else begin
      if (v && !wr) m_err = 1;
      if (rd && m_sv) m_pix = m_scan[rx];
      m_rdone = 0; m_fdone = 0;
      if (wr) begin m_fill[xc] = vv; m_cnt++; end
      case (ph0)
        0: begin m_ph = 1; m_rdone = 1; end
        1: m_ph = 2;
        2: if (m_cnt == XT) m_ph = 3;
        default: ;
      endcase
      if (ls) begin
        if (ph0 == 3) begin
          for (int i = 0; i < XT; i++) m_scan[i] = m_fill[i];
          m_sv = 1; m_cnt = 0; m_ph = 1; m_rdone = 1;
          if (m_row == YT - 1) begin m_row = 0; m_fdone = 1; end
          else m_row++;
        end else begin
`ifdef FB_UNDERRUN_CNT_EN
          if (m_und < 65535) m_und++;
`endif
        end
      end
    end
    #1;
    chk("row_done",   32'(fb.row_done),   32'(m_rdone));
    chk("frame_done", 32'(fb.frame_done), 32'(m_fdone));
    chk("pix_val",    32'(pix_val),       32'(m_pix));
    chk("err",        32'(err),           32'(m_err));
    chk("underrun",   32'(und),           32'(m_und));
    if (fb.row_done)   rdone_seen++;
    if (fb.frame_done) fdone_seen++;
  endtask

  task automatic idle();
    line_start = 1'b0; fb.vld = 1'b0; pix_rd = 1'b0;
  endtask

  // mode 0: val=x, 1: val=x+1000, 2: random
  task automatic fill(input int start, input int n, input int mode);
    for (int x = start; x < start + n; x++) begin
      fb.vld = 1'b1; fb.x_coord = 10'(x);
      fb.val = (mode == 0) ? 24'(x) : (mode == 1) ? 24'(x + 1000) : 24'($urandom);
      tick();
    end
    fb.vld = 1'b0;
  endtask

  task automatic rd(input int x);
    pix_rd = 1'b1; pix_x = 10'(x); tick(); pix_rd = 1'b0;
  endtask

  task automatic swap_line();
    line_start = 1'b1; tick(); line_start = 1'b0;
  endtask

  typedef struct {
    bit rd;
    int x;
    int exp;
  } rd_vec_t;

  rd_vec_t tbl [6];
  int exp_und1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 100, 100};
    tbl[1] = '{0, 5,   100};
    tbl[2] = '{1, 0,   0};
    tbl[3] = '{1, 639, 639};
    tbl[4] = '{1, 320, 320};
    tbl[5] = '{0, 1,   320};
`ifdef FB_UNDERRUN_CNT_EN
    exp_und1 = 1;
`else
    exp_und1 = 0;
`endif

    idle(); pix_x = '0; fb.x_coord = '0; fb.val = '0;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_pix", 32'(pix_val), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_und", 32'(und), 0);
    chk("rst_row_done", 32'(fb.row_done), 0);

    // Release: a single row_done, no frame_done, pixel output still 0.
    rst = 1'b1; rdone_seen = 0; fdone_seen = 0;
    tick();
    chk("rel_row_done_c1", 32'(fb.row_done), 1);
    repeat (3) tick();
    chk("rel_row_done_once", 32'(rdone_seen), 1);
    chk("rel_no_frame", 32'(fdone_seen), 0);
    chk("rel_pix0", 32'(pix_val), 0);

    // Full row, swap, table-driven reads.
    fill(0, XT, 0);
    tick();
    swap_line();
    chk("swap_row_done", 32'(fb.row_done), 1);
    tick();
    foreach (tbl[i]) begin
      pix_rd = tbl[i].rd; pix_x = 10'(tbl[i].x);
      tick();
      pix_rd = 1'b0;
      chk("tbl_rd", 32'(pix_val), 32'(tbl[i].exp));
    end

    // Underrun after 639 pixels: old row rescanned.
    fill(0, XT - 1, 1);
    swap_line();
    chk("underrun_cnt", 32'(und), 32'(exp_und1));
    chk("underrun_no_row_done", 32'(fb.row_done), 0);
    rd(100);
    chk("rescan", 32'(pix_val), 100);
    chk("err_clean", 32'(err), 0);
    fill(XT - 1, 1, 1);
    // Pixel offered while the row is complete is dropped.
    fb.vld = 1'b1; fb.x_coord = 10'd5; fb.val = 24'hABCDEF; tick(); fb.vld = 1'b0;
    chk("err_full", 32'(err), 1);
    swap_line();
    tick();
    rd(5);
    chk("full_drop_ram", 32'(pix_val), 1005);
    rd(100);
    chk("row2_rd", 32'(pix_val), 1100);
    // Out-of-range column is dropped and does not count toward the row.
    fb.vld = 1'b1; fb.x_coord = 10'd700; fb.val = 24'h123456; tick(); fb.vld = 1'b0;
    chk("err_range", 32'(err), 1);
    fill(0, XT, 2);
    swap_line();
    chk("range_no_count", 32'(fb.row_done), 1);
    chk("err_sticky", 32'(err), 1);
    tick();

    // Frame wrap: one frame_done per YT rows.
    rst = 1'b0; tick(); rst = 1'b1; tick(); tick();
    rdone_seen = 0; fdone_seen = 0;
    for (int r = 0; r < YT; r++) begin
      fill(0, XT, 2);
      swap_line();
      if (r == YT - 1) chk("frame_on_last", 32'(fb.frame_done), 1);
      tick();
    end
    chk("frame_once", 32'(fdone_seen), 1);
    chk("frame_rows", 32'(rdone_seen), YT);
    fdone_seen = 0;
    for (int r = 0; r < YT; r++) begin
      fill(0, XT, 2);
      swap_line();
      tick();
    end
    chk("frame_wrap", 32'(fdone_seen), 1);

    // Reset mid-row discards the partial row.
    fill(0, 300, 2);
    rst = 1'b0; tick();
    chk("mid_rst_pix", 32'(pix_val), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_und", 32'(und), 0);
    rst = 1'b1; tick();
    chk("mid_rel_row_done", 32'(fb.row_done), 1);
    tick();
    rd(5);
    chk("mid_no_scan", 32'(pix_val), 0);
    fill(0, 300, 2);
    swap_line();
    chk("mid_partial_no_swap", 32'(fb.row_done), 0);
    fill(300, XT - 300, 2);
    swap_line();
    chk("mid_fresh_swap", 32'(fb.row_done), 1);
    tick();

    // Randomized rows with gaps, junk pixels, early line starts, reads.
    for (int r = 0; r < 8; r++) begin
      int x;
      x = 0;
      while (x < XT) begin
        int sel;
        sel = $urandom_range(0, 15);
        pix_rd = 1'($urandom); pix_x = 10'($urandom_range(0, XT - 1));
        line_start = ($urandom_range(0, 199) == 0);
        if (sel == 0) begin
          fb.vld = 1'b1; fb.x_coord = 10'($urandom_range(XT, 1023)); fb.val = 24'($urandom);
        end else if (sel < 4) begin
          fb.vld = 1'b0;
        end else begin
          fb.vld = 1'b1; fb.x_coord = 10'(x); fb.val = 24'($urandom);
          if (m_ph == 2) x++;
        end
        tick();
      end
      idle();
      repeat ($urandom_range(0, 3)) begin
        fb.vld = 1'($urandom); fb.x_coord = 10'($urandom_range(0, XT - 1));
        pix_rd = 1'($urandom); pix_x = 10'($urandom_range(0, XT - 1));
        tick();
      end
      idle();
      swap_line();
      pix_rd = 1'b1; pix_x = 10'($urandom_range(0, XT - 1));
      tick();
      idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
